// File: rtl/sobel_calc_pkg.sv
// Shared types and constants for the Sobel datapath and its controller.
package sobel_pkg;

  localparam int DEF_PIXEL_W = 8;

  function automatic int acc_w(input int pw);
    return pw + 3;
  endfunction

  function automatic int sum_w(input int pw);
    return pw + 4;
  endfunction

  localparam int ACC_W = acc_w(DEF_PIXEL_W);
  localparam int SUM_W = sum_w(DEF_PIXEL_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW0 = 3'd1,
    ROW1 = 3'd2,
    ROW2 = 3'd3,
    MAG  = 3'd4,
    DONE = 3'd5
  } calc_state_t;

  // Indexed [row][col]; col 0 is the left column, row 0 the top row.
  localparam logic signed [2:0] KX [3][3] = '{
    '{-3'sd1, 3'sd0, 3'sd1},
    '{-3'sd2, 3'sd0, 3'sd2},
    '{-3'sd1, 3'sd0, 3'sd1}
  };

  localparam logic signed [2:0] KY [3][3] = '{
    '{-3'sd1, -3'sd2, -3'sd1},
    '{ 3'sd0,  3'sd0,  3'sd0},
    '{ 3'sd1,  3'sd2,  3'sd1}
  };

endpackage

// File: rtl/sobel_calc_if.sv
// Controller <-> gradient stage handshake: start/window in, done/busy/result out.
interface sobel_calc_if
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W
);
  logic                   start_calculation;
  logic [9*PIXEL_W-1:0]   window;
  logic                   calculation_done;
  logic                   busy;
  logic [PIXEL_W-1:0]     magnitude;
  logic                   edge_flag;

  modport master (
    output start_calculation, window,
    input  calculation_done, busy, magnitude, edge_flag
  );

  modport slave (
    input  start_calculation, window,
    output calculation_done, busy, magnitude, edge_flag
  );
endinterface

// File: rtl/sobel_calc_row_term.sv
// Combinational Gx/Gy contribution of one window row; row index 3 yields zero.
module sobel_row_term
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W
) (
  input  logic [1:0]                row_idx,
  input  logic [PIXEL_W-1:0]        p0,
  input  logic [PIXEL_W-1:0]        p1,
  input  logic [PIXEL_W-1:0]        p2,
  output logic signed [PIXEL_W+2:0] gx_term,
  output logic signed [PIXEL_W+2:0] gy_term
);

  localparam int AW = acc_w(PIXEL_W);

  // Coefficients are limited to {-2..2}, so each product is a shift and/or negate.
  function automatic logic signed [AW-1:0] coef_term(input logic signed [2:0] k,
                                                     input logic [PIXEL_W-1:0] p);
    logic signed [AW-1:0] v;
    v = $signed({3'b000, p});
    case (k)
      3'sd1:   coef_term = v;
      -3'sd1:  coef_term = -v;
      3'sd2:   coef_term = v <<< 1;
      -3'sd2:  coef_term = -(v <<< 1);
      default: coef_term = '0;
    endcase
  endfunction

  // Dot products of the selected kernel rows with the three pixels.
  always_comb begin
    gx_term = '0;
    gy_term = '0;
    if (row_idx <= 2'd2) begin
      gx_term = coef_term(KX[row_idx][0], p0) + coef_term(KX[row_idx][1], p1)
              + coef_term(KX[row_idx][2], p2);
      gy_term = coef_term(KY[row_idx][0], p0) + coef_term(KY[row_idx][1], p1)
              + coef_term(KY[row_idx][2], p2);
    end else begin
      gx_term = '0;
      gy_term = '0;
    end
  end

endmodule

// File: rtl/sobel_calc.sv
// Sobel gradient stage: captures a 3x3 window, accumulates Gx/Gy row by row,
// then produces a saturated |Gx|+|Gy| magnitude and a threshold flag.
module sobel_calc
  import sobel_pkg::*;
#(
  parameter int PIXEL_W   = DEF_PIXEL_W,
  parameter int THRESHOLD = 128
) (
  input logic         clk,
  input logic         rst,
  sobel_calc_if.slave bus
);

  localparam int AW = acc_w(PIXEL_W);
  localparam int SW = sum_w(PIXEL_W);
  localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIXEL_W) - 1);
  localparam logic [SW-1:0] THR_V   = SW'(THRESHOLD);

  calc_state_t          state_r;
  logic [9*PIXEL_W-1:0] win_r;
  logic signed [AW-1:0] gx_acc_r;
  logic signed [AW-1:0] gy_acc_r;
  logic [PIXEL_W-1:0]   magnitude_r;
  logic                 edge_flag_r;
  logic                 done_r;
  logic                 busy_r;

  logic [1:0]           row_idx_s;
  logic [PIXEL_W-1:0]   p0_s, p1_s, p2_s;
  logic signed [AW-1:0] gx_term_s, gy_term_s;
  logic [SW-1:0]        gx_abs_s, gy_abs_s, sum_s;
  logic [PIXEL_W-1:0]   sat_s;
  logic                 edge_s;

  // Route the captured row belonging to the current ROW state to the kernel term.
  always_comb begin
    row_idx_s = 2'd3;
    p0_s      = '0;
    p1_s      = '0;
    p2_s      = '0;
    case (state_r)
      ROW0: begin
        row_idx_s = 2'd0;
        p0_s = win_r[0*PIXEL_W +: PIXEL_W];
        p1_s = win_r[1*PIXEL_W +: PIXEL_W];
        p2_s = win_r[2*PIXEL_W +: PIXEL_W];
      end
      ROW1: begin
        row_idx_s = 2'd1;
        p0_s = win_r[3*PIXEL_W +: PIXEL_W];
        p1_s = win_r[4*PIXEL_W +: PIXEL_W];
        p2_s = win_r[5*PIXEL_W +: PIXEL_W];
      end
      ROW2: begin
        row_idx_s = 2'd2;
        p0_s = win_r[6*PIXEL_W +: PIXEL_W];
        p1_s = win_r[7*PIXEL_W +: PIXEL_W];
        p2_s = win_r[8*PIXEL_W +: PIXEL_W];
      end
      default: begin
        row_idx_s = 2'd3;
      end
    endcase
  end

  sobel_row_term #(.PIXEL_W(PIXEL_W)) u_row_term (
    .row_idx (row_idx_s),
    .p0      (p0_s),
    .p1      (p1_s),
    .p2      (p2_s),
    .gx_term (gx_term_s),
    .gy_term (gy_term_s)
  );

  // Absolute values, sum, saturation and threshold compare for the MAG state.
  always_comb begin
    gx_abs_s = '0;
    gy_abs_s = '0;
    if (gx_acc_r[AW-1]) begin
      gx_abs_s = SW'(-gx_acc_r);
    end else begin
      gx_abs_s = SW'(gx_acc_r);
    end
    if (gy_acc_r[AW-1]) begin
      gy_abs_s = SW'(-gy_acc_r);
    end else begin
      gy_abs_s = SW'(gy_acc_r);
    end
    sum_s = gx_abs_s + gy_abs_s;
    if (sum_s > PIX_MAX) begin
      sat_s = '1;
    end else begin
      sat_s = sum_s[PIXEL_W-1:0];
    end
    edge_s = (SW'(sat_s) >= THR_V);
  end

  // Sequencer and result registers. Leaving DONE behaves exactly like IDLE, so
  // a pending start is accepted there and throughput stays at one result per
  // five clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      win_r       <= '0;
      gx_acc_r    <= '0;
      gy_acc_r    <= '0;
      magnitude_r <= '0;
      edge_flag_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start_calculation) begin
            state_r  <= ROW0;
            win_r    <= bus.window;
            gx_acc_r <= '0;
            gy_acc_r <= '0;
            busy_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ROW0, ROW1, ROW2: begin
          gx_acc_r <= gx_acc_r + gx_term_s;
          gy_acc_r <= gy_acc_r + gy_term_s;
          if (state_r == ROW0) begin
            state_r <= ROW1;
          end else if (state_r == ROW1) begin
            state_r <= ROW2;
          end else begin
            state_r <= MAG;
          end
        end
        MAG: begin
          state_r     <= DONE;
          magnitude_r <= sat_s;
          edge_flag_r <= edge_s;
          done_r      <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.calculation_done = done_r;
  assign bus.busy             = busy_r;
  assign bus.magnitude        = magnitude_r;
  assign bus.edge_flag        = edge_flag_r;

endmodule

// File: tb/tb_sobel_calc.sv
// Randomized self-checking bench for sobel_calc against a plain-arithmetic Sobel model.
module tb_sobel_calc;

  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  sobel_calc_if #(.PIXEL_W(PW)) bus ();
  sobel_calc_if #(.PIXEL_W(PW)) bus60 ();

  sobel_calc #(.PIXEL_W(PW), .THRESHOLD(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sobel_calc #(.PIXEL_W(PW), .THRESHOLD(60)) dut60 (
    .clk (clk),
    .rst (rst),
    .bus (bus60)
  );

  assign bus60.start_calculation = bus.start_calculation;
  assign bus60.window            = bus.window;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.calculation_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int pix(input logic [9*PW-1:0] w, input int r, input int c);
    return int'(w[PW*(3*r+c) +: PW]);
  endfunction

  // Gx = weighted (right - left) per row, Gy = weighted (bottom - top) per column.
  function automatic void model(input logic [9*PW-1:0] w, input int thr,
                                output int mag, output int edge_f);
    int gx, gy, s, wt;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      wt = (i == 1) ? 2 : 1;
      gx += wt * (pix(w, i, 2) - pix(w, i, 0));
      gy += wt * (pix(w, 2, i) - pix(w, 0, i));
    end
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    mag = (s > 255) ? 255 : s;
    edge_f = (mag >= thr) ? 1 : 0;
  endfunction

  function automatic logic [9*PW-1:0] cols(input int l, input int m, input int r);
    logic [9*PW-1:0] w;
    for (int i = 0; i < 3; i++) begin
      w[PW*(3*i+0) +: PW] = PW'(l);
      w[PW*(3*i+1) +: PW] = PW'(m);
      w[PW*(3*i+2) +: PW] = PW'(r);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One calculation; optionally re-pulses start in ROW1 and scrambles the window after capture.
  task automatic run_calc(input string tag, input logic [9*PW-1:0] w, input bit poke);
    int m, e, m60, e60, c0;
    model(w, 128, m, e);
    model(w, 60, m60, e60);
    c0 = done_cnt;
    bus.window = w;
    bus.start_calculation = 1'b1;
    tick();
    bus.start_calculation = 1'b0;
    check({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    check({tag, ".done0"}, 32'(bus.calculation_done), 32'd0);
    if (poke) bus.window = ~w;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (poke && k == 1) bus.start_calculation = 1'b1;
      if (poke && k == 2) bus.start_calculation = 1'b0;
      if (k < 4) begin
        check({tag, ".done_early"}, 32'(bus.calculation_done), 32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      end else if (k == 4) begin
        check({tag, ".done"}, 32'(bus.calculation_done), 32'd1);
        check({tag, ".mag"}, 32'(bus.magnitude), 32'(m));
        check({tag, ".edge"}, 32'(bus.edge_flag), 32'(e));
        check({tag, ".edge60"}, 32'(bus60.edge_flag), 32'(e60));
      end else begin
        check({tag, ".done_end"}, 32'(bus.calculation_done), 32'd0);
        check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
      end
    end
    check({tag, ".npulse"}, 32'(done_cnt - c0), 32'd1);
  endtask

  initial begin
    logic [9*PW-1:0] w;
    int m, e, c0;
    bus.start_calculation = 1'b0;
    bus.window = '0;

    #12;
    check("rst.mag", 32'(bus.magnitude), 32'd0);
    check("rst.edge", 32'(bus.edge_flag), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.calculation_done), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_calc("flat", cols(100, 100, 100), 1'b0);
    run_calc("vstep", cols(0, 0, 255), 1'b0);
    run_calc("left50", cols(50, 0, 0), 1'b0);
    run_calc("ramp", cols(10, 15, 20), 1'b0);
    w = '0;
    w[PW*8 +: PW] = PW'(30);
    run_calc("diag", w, 1'b0);
    run_calc("poke", cols(0, 0, 200), 1'b1);

    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 9; j++) begin
        case ($urandom_range(0, 3))
          0: w[PW*j +: PW] = PW'(0);
          1: w[PW*j +: PW] = PW'(255);
          default: w[PW*j +: PW] = PW'($urandom_range(0, 255));
        endcase
      end
      run_calc("rand", w, i[0]);
    end

    // Start held high for 12 edges: results every 5 clocks.
    w = cols(7, 90, 40);
    model(w, 128, m, e);
    bus.window = w;
    bus.start_calculation = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      tick();
      if (k == 11) bus.start_calculation = 1'b0;
      check("hold.done", 32'(bus.calculation_done), (k % 5 == 4 && k <= 14) ? 32'd1 : 32'd0);
      check("hold.busy", 32'(bus.busy), (k <= 14) ? 32'd1 : 32'd0);
      if (k % 5 == 4 && k <= 14) check("hold.mag", 32'(bus.magnitude), 32'(m));
    end
    tick();

    // Asynchronous reset during ROW2 aborts the calculation.
    bus.window = cols(0, 0, 255);
    bus.start_calculation = 1'b1;
    tick();
    bus.start_calculation = 1'b0;
    tick();
    tick();
    c0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("arst.mag", 32'(bus.magnitude), 32'd0);
    check("arst.edge", 32'(bus.edge_flag), 32'd0);
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.calculation_done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("arst.nodone", 32'(done_cnt - c0), 32'd0);
    check("arst.idle", 32'(bus.busy), 32'd0);
    run_calc("post_rst", cols(50, 0, 0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
